// File: rtl/cpu_mem_arb_pkg.sv
// Shared encodings for the CPU memory-port arbiter: FSM states, requester ids
// and the full-word mask applied to reads.
package cpu_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_D = 2'd0;
    localparam req_id_t REQ_F = 2'd1;
    localparam req_id_t REQ_X = 2'd2;

    localparam logic [1:0] READ_MASK = 2'b11;

endpackage

// File: rtl/cpu_mem_arb_pick.sv
// Combinational winner selection: data first, fetch/DMA round-robin, and a
// forced fetch/DMA grant once the starvation counter is due.
module cpu_mem_arb_pick
    import cpu_mem_arb_pkg::*;
(
    input  logic    d_req,
    input  logic    f_req,
    input  logic    x_req,
    input  logic    last_x,
    input  logic    starve_due,
    output req_id_t win_id,
    output logic    win_vld
);

    always_comb begin
        win_id  = REQ_D;
        win_vld = 1'b0;
        // A due starvation grant only overrides data when fetch/DMA is actually waiting.
        if (d_req && !(starve_due && (f_req || x_req))) begin
            win_id  = REQ_D;
            win_vld = 1'b1;
        end else if (f_req && x_req) begin
            win_id  = last_x ? REQ_F : REQ_X;
            win_vld = 1'b1;
        end else if (f_req) begin
            win_id  = REQ_F;
            win_vld = 1'b1;
        end else if (x_req) begin
            win_id  = REQ_X;
            win_vld = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between data, fetch and DMA requesters, one transaction
// at a time. Define CPU_MEM_ARB_DMA_EN to enable the DMA (x_*) requester.
module cpu_mem_arbiter
    import cpu_mem_arb_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = 16,
    parameter int unsigned BITS         = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDRESS_BITS-1:0] d_addr,
    input  logic [BITS-1:0]         d_wdata,
    input  logic [1:0]              d_mask,
    input  logic                    f_req,
    input  logic [ADDRESS_BITS-1:0] f_addr,
    input  logic                    x_req,
    input  logic                    x_we,
    input  logic [ADDRESS_BITS-1:0] x_addr,
    input  logic [BITS-1:0]         x_wdata,
    input  logic [1:0]              x_mask,
    output logic                    d_ack,
    output logic                    f_ack,
    output logic                    x_ack,
    output logic [BITS-1:0]         d_rdata,
    output logic [BITS-1:0]         f_rdata,
    output logic [BITS-1:0]         x_rdata,
    output logic                    d_stall,
    output logic                    mem_valid,
    output logic                    mem_we,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic [BITS-1:0]         mem_wdata,
    output logic [1:0]              mem_mask,
    input  logic                    mem_ready,
    input  logic [BITS-1:0]         mem_rdata
);

`ifdef CPU_MEM_ARB_DMA_EN
    localparam logic DMA_EN = 1'b1;
`else
    localparam logic DMA_EN = 1'b0;
`endif

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    arb_state_t              state_q, state_d;
    req_id_t                 id_q, id_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [BITS-1:0]         wdata_q, wdata_d;
    logic [1:0]              mask_q, mask_d;
    logic                    we_q, we_d;
    logic                    last_x_q, last_x_d;
    logic [3:0]              starve_q, starve_d;
    logic [BITS-1:0]         d_rdata_q, d_rdata_d;
    logic [BITS-1:0]         f_rdata_q, f_rdata_d;
    logic [BITS-1:0]         x_rdata_q, x_rdata_d;

    logic    x_req_eff;
    logic    fx_pend;
    logic    starve_due;
    req_id_t win_id;
    logic    win_vld;

    assign x_req_eff  = x_req & DMA_EN;
    assign fx_pend    = f_req | x_req_eff;
    assign starve_due = (starve_q >= STARVE_LIM);

    cpu_mem_arb_pick u_pick (
        .d_req      (d_req),
        .f_req      (f_req),
        .x_req      (x_req_eff),
        .last_x     (last_x_q),
        .starve_due (starve_due),
        .win_id     (win_id),
        .win_vld    (win_vld)
    );

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q   <= IDLE;
            id_q      <= REQ_D;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= READ_MASK;
            we_q      <= 1'b0;
            last_x_q  <= 1'b1;
            starve_q  <= 4'd0;
            d_rdata_q <= '0;
            f_rdata_q <= '0;
            x_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            we_q      <= we_d;
            last_x_q  <= last_x_d;
            starve_q  <= starve_d;
            d_rdata_q <= d_rdata_d;
            f_rdata_q <= f_rdata_d;
            x_rdata_q <= x_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld)   state_d = ISSUE;
            ISSUE:   if (mem_ready) state_d = RESP;
            RESP:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        id_d      = id_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        we_d      = we_q;
        last_x_d  = last_x_q;
        starve_d  = starve_q;
        d_rdata_d = d_rdata_q;
        f_rdata_d = f_rdata_q;
        x_rdata_d = x_rdata_q;

        if (state_q == IDLE && win_vld) begin
            id_d = win_id;
            case (win_id)
                REQ_F: begin
                    addr_d  = f_addr;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    mask_d  = READ_MASK;
                end
                REQ_X: begin
                    addr_d  = x_addr;
                    wdata_d = x_wdata;
                    we_d    = x_we;
                    mask_d  = x_we ? x_mask : READ_MASK;
                end
                default: begin
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    we_d    = d_we;
                    mask_d  = d_we ? d_mask : READ_MASK;
                end
            endcase

            // Saturating count of data grants that kept fetch/DMA waiting.
            if (win_id == REQ_D) begin
                if (fx_pend && starve_q != 4'hF)
                    starve_d = starve_q + 4'd1;
            end else begin
                starve_d = 4'd0;
                last_x_d = (win_id == REQ_X);
            end
        end

        if (state_q == ISSUE && mem_ready && !we_q) begin
            case (id_q)
                REQ_F:   f_rdata_d = mem_rdata;
                REQ_X:   x_rdata_d = mem_rdata;
                default: d_rdata_d = mem_rdata;
            endcase
        end
    end

    always_comb begin
        mem_valid = (state_q == ISSUE);
        mem_we    = (state_q == ISSUE) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_mask  = mask_q;
        d_ack     = (state_q == RESP) && (id_q == REQ_D);
        f_ack     = (state_q == RESP) && (id_q == REQ_F);
        x_ack     = (state_q == RESP) && (id_q == REQ_X) && DMA_EN;
        d_rdata   = d_rdata_q;
        f_rdata   = f_rdata_q;
        x_rdata   = DMA_EN ? x_rdata_q : '0;
        d_stall   = d_req && !d_ack;
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter; expectations follow CPU_MEM_ARB_DMA_EN.
module tb_cpu_mem_arbiter;
    import cpu_mem_arb_pkg::*;

    logic        CLK = 1'b0;
    logic        RSTb = 1'b0;
    logic        d_req = 0, d_we = 0, f_req = 0, x_req = 0, x_we = 0;
    logic [15:0] d_addr = 0, f_addr = 0, x_addr = 0, d_wdata = 0, x_wdata = 0;
    logic [1:0]  d_mask = 0, x_mask = 0;
    logic        d_ack, f_ack, x_ack, d_stall, mem_valid, mem_we;
    logic [15:0] d_rdata, f_rdata, x_rdata, mem_addr, mem_wdata;
    logic [1:0]  mem_mask;
    logic        mem_ready = 0;
    logic [15:0] mem_rdata = 0;

    always #5 CLK = ~CLK;

    cpu_mem_arbiter #(.ADDRESS_BITS(16), .BITS(16), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RSTb(RSTb),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
        .f_req(f_req), .f_addr(f_addr),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata), .x_mask(x_mask),
        .d_ack(d_ack), .f_ack(f_ack), .x_ack(x_ack),
        .d_rdata(d_rdata), .f_rdata(f_rdata), .x_rdata(x_rdata), .d_stall(d_stall),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    typedef struct {req_id_t id; logic rd; logic [15:0] rdata;} ack_exp_t;
    typedef struct {logic [15:0] addr; logic we; logic [15:0] wdata; logic [1:0] mask; int cycles;} bus_exp_t;

    ack_exp_t ack_q[$];
    bus_exp_t bus_q[$];
    int n_vec = 0, n_miss = 0;
    int cyc = 0, wait_states = 0, ws_cnt = 0, run = 0, prev_ack = -1;
    bit gap_chk = 0;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'hA5A5);
    endfunction

    function automatic logic ack_of(input req_id_t w);
        case (w)
            REQ_D:   return d_ack;
            REQ_F:   return f_ack;
            default: return x_ack;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_rd(input req_id_t id, input logic [15:0] addr);
        bus_q.push_back('{addr, 1'b0, 16'h0, 2'b11, wait_states + 1});
        ack_q.push_back('{id, 1'b1, mem_fn(addr)});
    endtask

    task automatic exp_wr(input req_id_t id, input logic [15:0] addr, input logic [15:0] wd,
                          input logic [1:0] mask);
        bus_q.push_back('{addr, 1'b1, wd, mask, wait_states + 1});
        ack_q.push_back('{id, 1'b0, 16'h0});
    endtask

    // Raise/hold one request and wait for its ack; returns edges from request to ack.
    task automatic txn(input req_id_t who, input logic we, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [1:0] mask, output int lat);
        case (who)
            REQ_D: begin d_we = we; d_addr = addr; d_wdata = wd; d_mask = mask; d_req = 1'b1; end
            REQ_F: begin f_addr = addr; f_req = 1'b1; end
            default: begin x_we = we; x_addr = addr; x_wdata = wd; x_mask = mask; x_req = 1'b1; end
        endcase
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge CLK);
            if (ack_of(who)) begin
                lat = c - 1;
                break;
            end
        end
        check("ack_timeout", 64'(lat < 0), 64'd0);
        @(posedge CLK);
        #1;
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Bus responder plus monitor: compares bus fields and acks against the queues.
    always @(negedge CLK) begin
        int na;
        req_id_t aid;
        logic [15:0] ard;
        ack_exp_t ae;
        if (mem_valid) begin
            mem_ready = (ws_cnt >= wait_states);
            mem_rdata = mem_fn(mem_addr);
            ws_cnt++;
        end else begin
            mem_ready = 1'b0;
            ws_cnt = 0;
            run = 0;
        end
        if (RSTb) begin
            check("d_stall", 64'(d_stall), 64'(d_req & ~d_ack));
            if (mem_valid) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", 64'(mem_addr), 64'hFFFF_FFFF);
                end else begin
                    check("bus_fields",
                          {mem_addr, mem_we, mem_mask, (mem_we ? mem_wdata : 16'h0)},
                          {bus_q[0].addr, bus_q[0].we, bus_q[0].mask,
                           (bus_q[0].we ? bus_q[0].wdata : 16'h0)});
                    run++;
                    if (mem_ready) begin
                        check("valid_cycles", 64'(run), 64'(bus_q[0].cycles));
                        void'(bus_q.pop_front());
                        run = 0;
                    end
                end
            end
            na = int'(d_ack) + int'(f_ack) + int'(x_ack);
            if (na > 0) begin
                check("ack_onehot", 64'(na), 64'd1);
                aid = d_ack ? REQ_D : (f_ack ? REQ_F : REQ_X);
                ard = d_ack ? d_rdata : (f_ack ? f_rdata : x_rdata);
                if (ack_q.size() == 0) begin
                    check("ack_unexpected", 64'(aid), 64'hF);
                end else begin
                    ae = ack_q.pop_front();
                    check("ack_id", 64'(aid), 64'(ae.id));
                    if (ae.rd) check("ack_rdata", 64'(ard), 64'(ae.rdata));
                end
                if (gap_chk && prev_ack >= 0) check("ack_gap", 64'(cyc - prev_ack), 64'd3);
                prev_ack = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr_wdata", {mem_addr, mem_wdata}, 64'd0);
        check("rst_mem_mask", 64'(mem_mask), 64'd3);
        check("rst_acks", {d_ack, f_ack, x_ack}, 64'd0);
        check("rst_rdata", {d_rdata, f_rdata, x_rdata}, 64'd0);
        RSTb = 1'b1;
        @(posedge CLK);
        #1;

        // Single data read with zero wait states; read mask must be forced to 11.
        wait_states = 0;
        exp_rd(REQ_D, 16'h1234);
        txn(REQ_D, 1'b0, 16'h1234, 16'h0, 2'b01, lat);
        d_req = 1'b0;
        check("d_read_latency", 64'(lat), 64'd2);
        repeat (3) @(posedge CLK);
        #1;
        check("d_rdata_hold", 64'(d_rdata), 64'hBEEF);

        // Fetch (and DMA, when built in) held continuously.
        gap_chk = 1;
        prev_ack = -1;
`ifdef CPU_MEM_ARB_DMA_EN
        exp_rd(REQ_F, 16'h0100);
        exp_rd(REQ_X, 16'h0200);
        exp_rd(REQ_F, 16'h0102);
        exp_rd(REQ_X, 16'h0202);
        fork
            begin : f_drv
                int l;
                txn(REQ_F, 1'b0, 16'h0100, 16'h0, 2'b00, l);
                txn(REQ_F, 1'b0, 16'h0102, 16'h0, 2'b00, l);
                f_req = 1'b0;
            end
            begin : x_drv
                int l;
                txn(REQ_X, 1'b0, 16'h0200, 16'h0, 2'b00, l);
                txn(REQ_X, 1'b0, 16'h0202, 16'h0, 2'b00, l);
                x_req = 1'b0;
            end
        join
`else
        x_we = 1'b0;
        x_addr = 16'h0200;
        x_req = 1'b1;
        exp_rd(REQ_F, 16'h0100);
        exp_rd(REQ_F, 16'h0102);
        txn(REQ_F, 1'b0, 16'h0100, 16'h0, 2'b00, lat);
        txn(REQ_F, 1'b0, 16'h0102, 16'h0, 2'b00, lat);
        f_req = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check("x_rdata_zero", 64'(x_rdata), 64'd0);
        check("x_ack_zero", 64'(x_ack), 64'd0);
        x_req = 1'b0;
`endif
        gap_chk = 0;
        check("fx_drained", 64'(ack_q.size() + bus_q.size()), 64'd0);

        // Data held with fetch held: four data grants, then a forced fetch.
        for (int i = 0; i < 4; i++) exp_rd(REQ_D, 16'h0300 + 16'(i));
        exp_rd(REQ_F, 16'h0400);
        for (int i = 4; i < 8; i++) exp_rd(REQ_D, 16'h0300 + 16'(i));
        exp_rd(REQ_F, 16'h0402);
        fork
            begin : d_drv
                int l;
                for (int i = 0; i < 8; i++) txn(REQ_D, 1'b0, 16'h0300 + 16'(i), 16'h0, 2'b00, l);
                d_req = 1'b0;
            end
            begin : f_drv2
                int l;
                txn(REQ_F, 1'b0, 16'h0400, 16'h0, 2'b00, l);
                txn(REQ_F, 1'b0, 16'h0402, 16'h0, 2'b00, l);
                f_req = 1'b0;
            end
        join
        check("starve_drained", 64'(ack_q.size() + bus_q.size()), 64'd0);

        // High-byte store with three wait states.
        wait_states = 3;
`ifdef CPU_MEM_ARB_DMA_EN
        exp_wr(REQ_X, 16'h0500, 16'hAB00, 2'b10);
        txn(REQ_X, 1'b1, 16'h0500, 16'hAB00, 2'b10, lat);
        x_req = 1'b0;
`else
        exp_wr(REQ_D, 16'h0500, 16'hAB00, 2'b10);
        txn(REQ_D, 1'b1, 16'h0500, 16'hAB00, 2'b10, lat);
        d_req = 1'b0;
`endif
        check("store_latency", 64'(lat), 64'd5);

        // Reset while the bus waits for mem_ready.
        wait_states = 6;
        exp_rd(REQ_D, 16'h0600);
        d_we = 1'b0;
        d_addr = 16'h0600;
        d_req = 1'b1;
        lat = 0;
        for (int c = 0; c < 20 && !mem_valid; c++) begin
            @(posedge CLK);
            #1;
        end
        check("abort_reached_issue", 64'(mem_valid), 64'd1);
        @(posedge CLK);
        #2;
        RSTb = 1'b0;
        #1;
        check("abort_mem_valid", 64'(mem_valid), 64'd0);
        check("abort_rdata_clear", 64'(d_rdata), 64'd0);
        d_req = 1'b0;
        ack_q.delete();
        bus_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check("abort_no_ack", {d_ack, f_ack, x_ack, mem_valid}, 64'd0);
        end
        @(posedge CLK);
        #1;
        RSTb = 1'b1;
        wait_states = 0;
        @(posedge CLK);
        #1;
        exp_rd(REQ_D, 16'h1234);
        txn(REQ_D, 1'b0, 16'h1234, 16'h0, 2'b11, lat);
        d_req = 1'b0;
        check("post_reset_latency", 64'(lat), 64'd2);

        repeat (3) @(posedge CLK);
        #1;
        check("final_drained", 64'(ack_q.size() + bus_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
